// File: rtl/drum_pkg.sv
// Shared types and constants for the source-rate drum playback blocks.
// Velocity scaling lives here so every player applies the same gain law.
package drum_pkg;

    localparam int SAMPLE_W     = 16;
    localparam int VELOCITY_W   = 7;
    localparam int SRC_RATE_DIV = 2268;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } player_state_t;

    // One entry of the read/scale pipeline; velocity travels with its read.
    typedef struct packed {
        logic                  valid;
        logic                  silence;
        logic                  last;
        logic [VELOCITY_W-1:0] vel;
    } slot_t;

    // Gain is vel+1 (1..128), so vel=127 is exact unity after the >>>7.
    // It needs 9 bits to stay positive once treated as signed.
    function automatic logic signed [SAMPLE_W-1:0] scale_sample(
        input logic signed [SAMPLE_W-1:0] data,
        input logic [VELOCITY_W-1:0]      vel
    );
        logic signed [VELOCITY_W+1:0]          gain;
        logic signed [SAMPLE_W+VELOCITY_W+1:0] prod;
        gain = $signed({2'b00, vel} + 9'd1);
        prod = data * gain;
        return SAMPLE_W'(prod >>> VELOCITY_W);
    endfunction

endpackage

// File: rtl/source_tick_gen.sv
// Free-running divider producing a one-cycle tick every RATE_DIV clocks.
// The first tick lands RATE_DIV cycles after reset is released.
module source_tick_gen #(
    parameter int RATE_DIV = 2268
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CNT_W = $clog2(RATE_DIV);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATE_DIV - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (count_reg == LAST_CNT) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign tick = (count_reg == LAST_CNT);

endmodule

// File: rtl/drum_sample_player.sv
// Plays one drum sample per hit at the source rate, scaled by velocity.
// Emits exactly one output strobe per source period, silence included.
module drum_sample_player
    import drum_pkg::*;
#(
    parameter int ADDR_W   = 17,
    parameter int RATE_DIV = SRC_RATE_DIV,
    parameter int MEM_LAT  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trigger,
    input  logic [VELOCITY_W-1:0] velocity,
    input  logic [ADDR_W-1:0]     start_addr,
    input  logic [ADDR_W-1:0]     end_addr,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_rd,
    input  logic [SAMPLE_W-1:0]   mem_data,
    output logic [SAMPLE_W-1:0]   sample_out,
    output logic                  sample_out_valid,
    output logic                  busy
);
    localparam int PIPE_D = MEM_LAT + 2;

    logic                  tick;
    player_state_t         state_reg;
    logic                  pend_reg;
    logic [VELOCITY_W-1:0] hit_vel_reg;
    logic [ADDR_W-1:0]     hit_start_reg;
    logic [ADDR_W-1:0]     hit_end_reg;
    logic [VELOCITY_W-1:0] vel_reg;
    logic [ADDR_W-1:0]     addr_reg;
    logic [ADDR_W-1:0]     end_reg;
    logic [VELOCITY_W-1:0] rd_vel;
    logic [ADDR_W-1:0]     rd_addr;
    logic [ADDR_W-1:0]     rd_end;
    logic                  rd_last;
    logic [ADDR_W-1:0]     mem_addr_reg;
    logic                  mem_rd_reg;
    slot_t                 slot_in_reg;
    slot_t [PIPE_D-2:0]    pipe_reg;
    logic [SAMPLE_W-1:0]   data_reg;
    logic [SAMPLE_W-1:0]   sample_out_reg;
    logic                  out_valid_reg;
    logic                  out_last_reg;
    logic                  busy_reg;

    source_tick_gen #(
        .RATE_DIV(RATE_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // A pending hit replaces the running sample at the next tick boundary.
    assign rd_addr = pend_reg ? hit_start_reg : addr_reg;
    assign rd_end  = pend_reg ? hit_end_reg   : end_reg;
    assign rd_vel  = pend_reg ? hit_vel_reg   : vel_reg;
    assign rd_last = (rd_addr == rd_end);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            pend_reg      <= 1'b0;
            hit_vel_reg   <= '0;
            hit_start_reg <= '0;
            hit_end_reg   <= '0;
            vel_reg       <= '0;
            addr_reg      <= '0;
            end_reg       <= '0;
            mem_addr_reg  <= '0;
            mem_rd_reg    <= 1'b0;
            slot_in_reg   <= '0;
            busy_reg      <= 1'b0;
        end else begin
            mem_rd_reg  <= 1'b0;
            slot_in_reg <= '0;
            if (out_valid_reg && out_last_reg) begin
                busy_reg <= 1'b0;
            end
            if (tick) begin
                if (pend_reg || state_reg == PLAY) begin
                    mem_rd_reg   <= 1'b1;
                    mem_addr_reg <= rd_addr;
                    slot_in_reg  <= slot_t'{valid: 1'b1, silence: 1'b0, last: rd_last, vel: rd_vel};
                    busy_reg     <= 1'b1;
                    pend_reg     <= 1'b0;
                    vel_reg      <= rd_vel;
                    end_reg      <= rd_end;
                    addr_reg     <= rd_addr + ADDR_W'(1);
                    state_reg    <= rd_last ? IDLE : PLAY;
                end else begin
                    slot_in_reg <= slot_t'{valid: 1'b1, silence: 1'b1, last: 1'b0, vel: '0};
                end
            end
            // Capture after the tick logic so a hit on the tick cycle stays pending.
            if (trigger && velocity != '0 && end_addr >= start_addr) begin
                pend_reg      <= 1'b1;
                hit_vel_reg   <= velocity;
                hit_start_reg <= start_addr;
                hit_end_reg   <= end_addr;
            end
        end
    end

    // Stage k of the slot pipeline is pipe_reg[k-1]; stage MEM_LAT lines up with mem_data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pipe_reg       <= '0;
            data_reg       <= '0;
            sample_out_reg <= '0;
            out_valid_reg  <= 1'b0;
            out_last_reg   <= 1'b0;
        end else begin
            pipe_reg <= {pipe_reg[MEM_LAT-1:0], slot_in_reg};
            if (pipe_reg[MEM_LAT-1].valid && !pipe_reg[MEM_LAT-1].silence) begin
                data_reg <= mem_data;
            end
            out_valid_reg <= pipe_reg[MEM_LAT].valid;
            out_last_reg  <= pipe_reg[MEM_LAT].valid && pipe_reg[MEM_LAT].last;
            if (pipe_reg[MEM_LAT].valid && !pipe_reg[MEM_LAT].silence) begin
                sample_out_reg <= scale_sample(data_reg, pipe_reg[MEM_LAT].vel);
            end else begin
                sample_out_reg <= '0;
            end
        end
    end

    assign mem_addr         = mem_addr_reg;
    assign mem_rd           = mem_rd_reg;
    assign sample_out       = sample_out_reg;
    assign sample_out_valid = out_valid_reg;
    assign busy             = busy_reg;

endmodule

// File: tb/tb_drum_sample_player.sv
// Bench for drum_sample_player: directed hits plus random hits/resets,
// checked against a per-tick playback model with expected-cycle queues.
module tb_drum_sample_player;

    localparam int ADDR_W    = 17;
    localparam int RATE_DIV  = 16;
    localparam int MEM_LAT   = 2;
    localparam int LAT_EDGES = MEM_LAT + 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              trigger = 1'b0;
    logic [6:0]        velocity = '0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic [ADDR_W-1:0] end_addr = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [15:0]       mem_data;
    logic [15:0]       sample_out;
    logic              sample_out_valid;
    logic              busy;

    logic signed [15:0] mem [0:(1<<ADDR_W)-1];
    logic [15:0]        d1 = 16'h5a5a;
    logic [15:0]        d2 = 16'h5a5a;

    typedef struct {
        int t;
        int val;
    } exp_t;

    exp_t out_q[$];
    exp_t rd_q[$];
    int   got_q[$];
    int   want_q[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // reference model state
    int   since = 0;
    bit   pend = 1'b0;
    bit   playing = 1'b0;
    int   p_vel, p_start, p_end;
    int   m_addr, m_end, m_vel;
    logic busy_exp = 1'b0;
    int   last_out = -1;

    always #5 clk = ~clk;

    drum_sample_player #(
        .ADDR_W  (ADDR_W),
        .RATE_DIV(RATE_DIV),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .trigger         (trigger),
        .velocity        (velocity),
        .start_addr      (start_addr),
        .end_addr        (end_addr),
        .mem_addr        (mem_addr),
        .mem_rd          (mem_rd),
        .mem_data        (mem_data),
        .sample_out      (sample_out),
        .sample_out_valid(sample_out_valid),
        .busy            (busy)
    );

    // Fixed-latency memory; junk outside the valid cycle exposes misaligned captures.
    always @(posedge clk) begin
        d1 <= mem_rd ? mem[mem_addr] : 16'h5a5a;
        d2 <= d1;
    end
    assign mem_data = d2;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Each source slot: a pending hit starts over, a playing sample advances, otherwise silence.
    task automatic run_model();
        int  a, e, v;
        bit  issued;
        forever begin
            @(posedge clk);
            cyc++;
            issued = 1'b0;
            if (!rst) begin
                since = 0;
                pend = 1'b0;
                playing = 1'b0;
                out_q.delete();
                rd_q.delete();
                busy_exp = 1'b0;
                last_out = -1;
            end else begin
                if (since == RATE_DIV - 1) begin
                    if (pend || playing) begin
                        if (pend) begin
                            a = p_start; e = p_end; v = p_vel; pend = 1'b0;
                        end else begin
                            a = m_addr; e = m_end; v = m_vel;
                        end
                        rd_q.push_back(exp_t'{t: cyc, val: a});
                        out_q.push_back(exp_t'{t: cyc + LAT_EDGES, val: (mem[a] * (v + 1)) >>> 7});
                        if (a == e) begin
                            playing = 1'b0;
                            last_out = cyc + LAT_EDGES;
                        end else begin
                            playing = 1'b1;
                            m_addr = a + 1; m_end = e; m_vel = v;
                        end
                        issued = 1'b1;
                    end else begin
                        out_q.push_back(exp_t'{t: cyc + LAT_EDGES, val: 0});
                    end
                end
                since = (since + 1) % RATE_DIV;
                if (issued) busy_exp = 1'b1;
                else if (busy_exp && cyc - 1 == last_out) busy_exp = 1'b0;
                if (trigger && velocity != 0 && end_addr >= start_addr) begin
                    pend = 1'b1;
                    p_vel = int'(velocity);
                    p_start = int'(start_addr);
                    p_end = int'(end_addr);
                end
            end
        end
    endtask

    task automatic run_monitor();
        exp_t e;
        logic exp_valid, exp_rd;
        forever begin
            @(negedge clk);
            check("busy", busy, busy_exp);
            exp_valid = (out_q.size() > 0 && out_q[0].t == cyc);
            check("sample_out_valid", sample_out_valid, exp_valid);
            if (exp_valid) begin
                e = out_q.pop_front();
                check("sample_out", $signed(sample_out), e.val);
            end
            if (sample_out_valid) got_q.push_back(int'($signed(sample_out)));
            exp_rd = (rd_q.size() > 0 && rd_q[0].t == cyc);
            check("mem_rd", mem_rd, exp_rd);
            if (exp_rd) begin
                e = rd_q.pop_front();
                check("mem_addr", mem_addr, e.val);
            end
        end
    endtask

    task automatic hit(input int vel, input int s, input int e);
        trigger = 1'b1;
        velocity = 7'(vel);
        start_addr = ADDR_W'(s);
        end_addr = ADDR_W'(e);
        @(negedge clk);
        trigger = 1'b0;
        velocity = '0;
        start_addr = '0;
        end_addr = '0;
    endtask

    // Align just after a strobe so the next hit is taken at the following tick.
    task automatic sync_strobe();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!sample_out_valid && k < 3 * RATE_DIV);
        check("sync_strobe", sample_out_valid, 1'b1);
        #1;
        got_q.delete();
    endtask

    task automatic wait_got(input int n);
        int k = 0;
        while (got_q.size() < n && k < (n + 2) * RATE_DIV) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("strobe_count", got_q.size(), n);
    endtask

    task automatic check_got(input string tag);
        for (int i = 0; i < want_q.size(); i++) begin
            check($sformatf("%s[%0d]", tag, i), (i < got_q.size()) ? got_q[i] : -99999, want_q[i]);
        end
    endtask

    initial begin
        int k;
        int r, s, e;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[10] = 16'sd100;
        mem[11] = -16'sd200;
        mem[12] = 16'sd32767;
        mem[13] = -16'sd32768;
        mem[20] = 16'sd1000;
        mem[40] = 16'sd1234;

        fork
            run_model();
            run_monitor();
        join_none

        // reset state
        repeat (3) @(negedge clk);
        check("rst_sample_out", sample_out, 0);
        check("rst_valid", sample_out_valid, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_busy", busy, 0);

        // idle: a zero strobe every RATE_DIV cycles, first one a tick plus pipeline after release
        rst = 1'b1;
        got_q.delete();
        repeat (5 * RATE_DIV) @(negedge clk);
        #1;
        want_q = '{0, 0, 0, 0};
        check("idle_count", got_q.size(), 4);
        check_got("idle");

        // unity velocity, then half velocity, then a velocity-0 hit
        sync_strobe();
        hit(127, 10, 13);
        wait_got(5);
        want_q = '{100, -200, 32767, -32768, 0};
        check_got("vel127");
        check("vel127_busy_after", busy, 0);

        sync_strobe();
        hit(63, 10, 13);
        wait_got(5);
        want_q = '{50, -100, 16383, -16384, 0};
        check_got("vel63");

        sync_strobe();
        hit(0, 10, 13);
        wait_got(3);
        want_q = '{0, 0, 0};
        check_got("vel0");
        check("vel0_busy", busy, 0);

        // retrigger while the second sample is still in the read pipeline
        sync_strobe();
        hit(127, 10, 13);
        k = 0;
        while (!(mem_rd && mem_addr == 11) && k < 3 * RATE_DIV) begin
            @(negedge clk);
            k++;
        end
        check("rd11_seen", mem_rd && mem_addr == 11, 1'b1);
        hit(63, 20, 20);
        wait_got(4);
        want_q = '{100, -200, 500, 0};
        check_got("retrigger");

        // end before start is ignored; of two hits before one tick, the second wins
        sync_strobe();
        hit(127, 9, 5);
        wait_got(3);
        want_q = '{0, 0, 0};
        check_got("invalid");
        check("invalid_busy", busy, 0);

        sync_strobe();
        hit(127, 30, 31);
        hit(127, 40, 40);
        wait_got(3);
        want_q = '{1234, 0, 0};
        check_got("second_wins");

        // one-cycle reset mid-play
        sync_strobe();
        hit(127, 10, 13);
        k = 0;
        while (!mem_rd && k < 3 * RATE_DIV) begin
            @(negedge clk);
            k++;
        end
        rst = 1'b0;
        @(negedge clk);
        check("midrst_sample_out", sample_out, 0);
        check("midrst_valid", sample_out_valid, 0);
        check("midrst_mem_rd", mem_rd, 0);
        check("midrst_busy", busy, 0);
        rst = 1'b1;
        k = 0;
        while (k < 3 * RATE_DIV) begin
            @(negedge clk);
            k++;
            if (sample_out_valid) break;
        end
        // first tick RATE_DIV cycles after release, then the read/scale latency
        check("first_strobe_after_rst", k, RATE_DIV + MEM_LAT + 2);
        check("first_strobe_value", sample_out, 0);

        // random hits, invalid hits and occasional resets
        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 30)) @(negedge clk);
            r = $urandom_range(0, 19);
            if (r == 0) begin
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end else begin
                s = $urandom_range(0, 200);
                e = s + $urandom_range(0, 6) - ((r < 5) ? 3 : 0);
                if (e < 0) e = 0;
                hit((r < 3) ? 0 : $urandom_range(1, 127), s, e);
            end
        end
        repeat (12 * RATE_DIV) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
